// File: rtl/mem_access_ctrl_if.sv
// Bundle of the signals between the EX/MEM stage, the data-memory bus and the
// MEM/WB enables that the MEM-stage access sequencer drives.
interface mem_access_ctrl_if #(
  parameter int N = 32
);
  // EX/MEM stage outputs
  logic         ExMem_MemRead;
  logic         ExMem_MemWrite;
  logic         ExMem_Regwrite;
  logic [N-1:0] ExMem_AluResBypass;
  logic [N-1:0] ExMem_StoreData;
  // memory handshake and control inputs
  logic         mem_ready;
  logic         err_clr;
  // memory request bus
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  // pipeline control and status
  logic         stall;
  logic         en_MemWb;
  logic         wb_Regwrite;
  logic         bus_err;
  logic [31:0]  stall_cnt;

  // Sequencer side
  modport master (
    input  ExMem_MemRead, ExMem_MemWrite, ExMem_Regwrite,
    input  ExMem_AluResBypass, ExMem_StoreData,
    input  mem_ready, err_clr,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall, en_MemWb, wb_Regwrite, bus_err, stall_cnt
  );

  // Pipeline/memory side
  modport slave (
    output ExMem_MemRead, ExMem_MemWrite, ExMem_Regwrite,
    output ExMem_AluResBypass, ExMem_StoreData,
    output mem_ready, err_clr,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall, en_MemWb, wb_Regwrite, bus_err, stall_cnt
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: request/ready handshake, pipeline
// stall and MEM/WB enable generation, wait-state timeout with sticky error,
// and a saturating stall-cycle counter.
module mem_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,  // active-high asynchronous reset
  mem_access_ctrl_if.master bus
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              bus_err_q;
  logic [31:0]       stall_cnt_q;

  logic access, conflict, req, stall, timeout_hit, err_set;

  assign access   = bus.ExMem_MemRead | bus.ExMem_MemWrite;
  assign conflict = bus.ExMem_MemRead & bus.ExMem_MemWrite;

  // State register and wait counter
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state logic and memory request generation
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    req           = 1'b0;
    timeout_hit   = 1'b0;
    case (state)
      IDLE: begin
        req = access;
        if (access && !bus.mem_ready) begin
          state_next    = ACCESS;
          wait_cnt_next = '0;
        end
      end
      ACCESS: begin
        req           = 1'b1;
        wait_cnt_next = wait_cnt + 1'b1;
        if (bus.mem_ready) begin
          state_next = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          // mem_ready on this same cycle would have won above
          state_next  = ERROR;
          timeout_hit = 1'b1;
        end
      end
      ERROR: begin
        // requests are suppressed until software acknowledges the fault
        if (bus.err_clr) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign stall   = req & ~bus.mem_ready;
  assign err_set = timeout_hit | (conflict & (state != ERROR));

  // Sticky bus error: a new fault in the same cycle outranks the clear
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)               bus_err_q <= 1'b0;
    else if (err_set)        bus_err_q <= 1'b1;
    else if (bus.err_clr)    bus_err_q <= 1'b0;
  end

  // Saturating count of stalled cycles, cleared only by reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                              stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.mem_req     = req;
  assign bus.mem_we      = bus.ExMem_MemWrite;  // a read+write conflict resolves to a write
  assign bus.mem_addr    = bus.ExMem_AluResBypass;
  assign bus.mem_wdata   = bus.ExMem_StoreData;
  assign bus.stall       = stall;
  assign bus.en_MemWb    = ~stall;
  // the faulting and all following instructions retire without a register write
  assign bus.wb_Regwrite = bus.ExMem_Regwrite & (state != ERROR) & ~timeout_hit;
  assign bus.bus_err     = bus_err_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of single-cycle vectors in IDLE
// plus hand-written sequences for wait states, timeout, late ready and reset.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_cnt = 32'd0;
  int   stall_seen;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.N(32)) bus ();

  mem_access_ctrl #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rd, wr, rw, rdy, clr;
    logic [31:0] addr, wdata;
    logic        exp_req, exp_we, exp_stall, exp_wbrw, exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end else
      $display("ok   %s = %b", name, act);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else
      $display("ok   %s = 0x%0h", name, act);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic rw,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.ExMem_MemRead      = rd;
    bus.ExMem_MemWrite     = wr;
    bus.ExMem_Regwrite     = rw;
    bus.ExMem_AluResBypass = addr;
    bus.ExMem_StoreData    = wdata;
  endtask

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rd   wr   rw   rdy  clr  addr          wdata         req  we   stl  wbrw err
    vecs[0] = '{1'b0,1'b0,1'b1,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b1,1'b0};
    vecs[1] = '{1'b1,1'b0,1'b1,1'b1,1'b0,32'h0000_0100,32'h0000_0000,1'b1,1'b0,1'b0,1'b1,1'b0};
    vecs[2] = '{1'b1,1'b0,1'b1,1'b1,1'b0,32'h0000_0104,32'h0000_0000,1'b1,1'b0,1'b0,1'b1,1'b0};
    vecs[3] = '{1'b0,1'b1,1'b0,1'b1,1'b0,32'h0000_0200,32'hDEAD_BEEF,1'b1,1'b1,1'b0,1'b0,1'b0};
    vecs[4] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[5] = '{1'b1,1'b1,1'b1,1'b1,1'b0,32'h0000_0300,32'h1234_5678,1'b1,1'b1,1'b0,1'b1,1'b0};
    vecs[6] = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b0,1'b1};
    vecs[7] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,1'b0,1'b0,1'b0,1'b0,1'b0};

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_ready = 1'b0;
    bus.err_clr   = 1'b0;

    // reset state
    @(negedge clk); @(negedge clk);
    #1;
    check1("rst.mem_req", bus.mem_req, 1'b0);
    check1("rst.stall", bus.stall, 1'b0);
    check1("rst.en_MemWb", bus.en_MemWb, 1'b1);
    check1("rst.bus_err", bus.bus_err, 1'b0);
    check32("rst.stall_cnt", bus.stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // single-cycle vectors, all of which leave the sequencer in IDLE
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].wr, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      bus.mem_ready = vecs[i].rdy;
      bus.err_clr   = vecs[i].clr;
      #1;
      check1($sformatf("vec%0d.mem_req", i), bus.mem_req, vecs[i].exp_req);
      if (vecs[i].exp_req) begin
        check1($sformatf("vec%0d.mem_we", i), bus.mem_we, vecs[i].exp_we);
        check32($sformatf("vec%0d.mem_addr", i), bus.mem_addr, vecs[i].addr);
        check32($sformatf("vec%0d.mem_wdata", i), bus.mem_wdata, vecs[i].wdata);
      end
      check1($sformatf("vec%0d.stall", i), bus.stall, vecs[i].exp_stall);
      check1($sformatf("vec%0d.en_MemWb", i), bus.en_MemWb, ~vecs[i].exp_stall);
      check1($sformatf("vec%0d.wb_Regwrite", i), bus.wb_Regwrite, vecs[i].exp_wbrw);
      check1($sformatf("vec%0d.bus_err", i), bus.bus_err, vecs[i].exp_err);
    end
    bus.err_clr = 1'b0;
    check32("vec.stall_cnt", bus.stall_cnt, exp_cnt);

    // store with 3 wait states: ready on the 4th request cycle
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'hA5A5_0001);
      bus.mem_ready = (c == 3);
      #1;
      check1($sformatf("st3.c%0d.stall", c), bus.stall, (c < 3));
      check1($sformatf("st3.c%0d.en_MemWb", c), bus.en_MemWb, (c == 3));
      check1($sformatf("st3.c%0d.mem_req", c), bus.mem_req, 1'b1);
      check1($sformatf("st3.c%0d.mem_we", c), bus.mem_we, 1'b1);
      check32($sformatf("st3.c%0d.mem_addr", c), bus.mem_addr, 32'h0000_0400);
      check32($sformatf("st3.c%0d.mem_wdata", c), bus.mem_wdata, 32'hA5A5_0001);
    end
    exp_cnt = exp_cnt + 32'd3;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_ready = 1'b0;
    #1;
    check32("st3.stall_cnt", bus.stall_cnt, exp_cnt);
    check1("st3.mem_req_after", bus.mem_req, 1'b0);

    // load that never gets ready: 1 IDLE cycle + 15 ACCESS cycles, then ERROR
    stall_seen = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0);
      #1;
      if (bus.stall) stall_seen++;
      if (c == 14) check1("to.c14.wb_Regwrite", bus.wb_Regwrite, 1'b1);
      if (c == 15) begin
        check1("to.c15.wb_Regwrite", bus.wb_Regwrite, 1'b0);
        check1("to.c15.bus_err", bus.bus_err, 1'b0);
      end
    end
    check32("to.stall_cycles", 32'(stall_seen), 32'd16);
    exp_cnt = exp_cnt + 32'd16;
    @(negedge clk);
    #1;
    check1("to.err.stall", bus.stall, 1'b0);
    check1("to.err.mem_req", bus.mem_req, 1'b0);
    check1("to.err.en_MemWb", bus.en_MemWb, 1'b1);
    check1("to.err.wb_Regwrite", bus.wb_Regwrite, 1'b0);
    check1("to.err.bus_err", bus.bus_err, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0504, 32'h0);
    #1;
    check1("to.next.mem_req", bus.mem_req, 1'b0);
    check1("to.next.wb_Regwrite", bus.wb_Regwrite, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.err_clr = 1'b1;
    #1;
    check1("to.clr.bus_err_before", bus.bus_err, 1'b1);
    @(negedge clk);
    bus.err_clr = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0508, 32'h0);
    bus.mem_ready = 1'b1;
    #1;
    check1("to.clr.bus_err", bus.bus_err, 1'b0);
    check1("to.clr.mem_req_idle", bus.mem_req, 1'b1);
    check1("to.clr.stall", bus.stall, 1'b0);
    check32("to.stall_cnt", bus.stall_cnt, exp_cnt);

    // ready arrives on exactly the 15th ACCESS cycle: normal completion
    stall_seen = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b1, 1'b0, 1'b1, 32'h0000_0600, 32'h0);
      bus.mem_ready = (c == 15);
      #1;
      if (bus.stall) stall_seen++;
      if (c == 15) begin
        check1("late.c15.stall", bus.stall, 1'b0);
        check1("late.c15.en_MemWb", bus.en_MemWb, 1'b1);
        check1("late.c15.wb_Regwrite", bus.wb_Regwrite, 1'b1);
      end
    end
    check32("late.stall_cycles", 32'(stall_seen), 32'd15);
    exp_cnt = exp_cnt + 32'd15;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_ready = 1'b0;
    #1;
    check1("late.bus_err", bus.bus_err, 1'b0);
    check32("late.stall_cnt", bus.stall_cnt, exp_cnt);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0604, 32'h0);
    bus.mem_ready = 1'b1;
    #1;
    check1("late.idle.mem_req", bus.mem_req, 1'b1);
    check1("late.idle.stall", bus.stall, 1'b0);

    // reset pulsed in the middle of a 5-wait-state load
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0700, 32'h0);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check1("rst5.pre.stall", bus.stall, 1'b1);
    rst_n = 1'b1;
    #1;
    check32("rst5.stall_cnt", bus.stall_cnt, 32'd0);
    check1("rst5.bus_err", bus.bus_err, 1'b0);
    check1("rst5.en_MemWb_held", bus.en_MemWb, 1'b0);
    bus.ExMem_MemRead = 1'b0;
    #1;
    check1("rst5.mem_req", bus.mem_req, 1'b0);
    check1("rst5.stall", bus.stall, 1'b0);
    check1("rst5.en_MemWb", bus.en_MemWb, 1'b1);
    bus.ExMem_MemRead = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check32("rst5.rel.stall_cnt", bus.stall_cnt, 32'd0);
    check1("rst5.rel.stall", bus.stall, 1'b1);
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      bus.mem_ready = (c == 5);
      #1;
      check1($sformatf("rst5.c%0d.stall", c), bus.stall, (c < 5));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_ready = 1'b0;
    #1;
    check32("rst5.final.stall_cnt", bus.stall_cnt, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
